// File: rtl/tsn_queue_update.sv
// Descriptor update stage: holds one enqueue request until the egress gate for its
// traffic class opens, then presents {qnum, addr} downstream, or drops it after bounded retries.
module tsn_queue_update #(
    parameter int QNUM_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int NPORTS      = 4,
    parameter int NTC         = 8,
    parameter int EXPRESS_MIN = 6,
    parameter int MAX_RETRY   = 15,
    parameter int RETRY_W     = 4,
    localparam int TC_W       = $clog2(NTC),
    localparam int PORT_W     = $clog2(NPORTS),
    localparam int IDX_W      = $clog2(NPORTS * NTC)
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [QNUM_W-1:0]        in_qnum,
    input  logic [TC_W-1:0]          in_tc,
    input  logic [PORT_W-1:0]        in_port_i,
    input  logic [PORT_W:0]          in_port_o,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [NPORTS*NTC-1:0]    port_state,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [QNUM_W+ADDR_W-1:0] out_desc,
    output logic [PORT_W-1:0]        out_port,
    output logic [PORT_W-1:0]        out_port_i,
    output logic                     out_express,
    output logic                     drop_pulse,
    output logic [15:0]              drop_cnt
);

    typedef enum logic [2:0] {IDLE, LOAD, JUDGE, WRITE, DROP} state_t;

    state_t                     state_q;
    logic [QNUM_W-1:0]          qnum_q;
    logic [TC_W-1:0]            tc_q;
    logic [PORT_W-1:0]          port_i_q;
    logic [PORT_W:0]            port_o_q;
    logic [ADDR_W-1:0]          addr_q;
    logic                       port_ok_q;
    logic [IDX_W-1:0]           gate_idx_q;
    logic                       express_q;
    logic [RETRY_W-1:0]         retry_q;
    logic                       out_vld_q;
    logic [QNUM_W+ADDR_W-1:0]   out_desc_q;
    logic [PORT_W-1:0]          out_port_q;
    logic [PORT_W-1:0]          out_port_i_q;
    logic                       out_express_q;
    logic                       drop_pulse_q;
    logic [15:0]                drop_cnt_q;

    logic [IDX_W-1:0]           gate_idx_d;
    logic                       port_ok_d;
    logic                       express_d;
    logic                       gate_open_d;
    logic                       retry_last_d;
    logic [15:0]                drop_cnt_d;

    // Gate index is only meaningful for a valid port; an invalid port never reaches the lookup.
    always_comb begin
        gate_idx_d   = IDX_W'(32'(port_o_q) * NTC + 32'(tc_q));
        port_ok_d    = (32'(port_o_q) < NPORTS);
        express_d    = (32'(tc_q) >= EXPRESS_MIN);
        gate_open_d  = port_state[gate_idx_q];
        retry_last_d = (MAX_RETRY != 0) && (retry_q == RETRY_W'(MAX_RETRY - 1));
        drop_cnt_d   = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            qnum_q        <= '0;
            tc_q          <= '0;
            port_i_q      <= '0;
            port_o_q      <= '0;
            addr_q        <= '0;
            port_ok_q     <= 1'b0;
            gate_idx_q    <= '0;
            express_q     <= 1'b0;
            retry_q       <= '0;
            out_vld_q     <= 1'b0;
            out_desc_q    <= '0;
            out_port_q    <= '0;
            out_port_i_q  <= '0;
            out_express_q <= 1'b0;
            drop_pulse_q  <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            drop_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        qnum_q   <= in_qnum;
                        tc_q     <= in_tc;
                        port_i_q <= in_port_i;
                        port_o_q <= in_port_o;
                        addr_q   <= in_addr;
                        retry_q  <= '0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    port_ok_q  <= port_ok_d;
                    gate_idx_q <= gate_idx_d;
                    express_q  <= express_d;
                    state_q    <= JUDGE;
                end
                JUDGE: begin
                    if (!port_ok_q || (!gate_open_d && retry_last_d)) begin
                        drop_pulse_q <= 1'b1;
                        drop_cnt_q   <= drop_cnt_d;
                        state_q      <= DROP;
                    end else if (gate_open_d) begin
                        out_vld_q     <= 1'b1;
                        out_desc_q    <= {qnum_q, addr_q};
                        out_port_q    <= port_o_q[PORT_W-1:0];
                        out_port_i_q  <= port_i_q;
                        out_express_q <= express_q;
                        state_q       <= WRITE;
                    end else begin
                        retry_q <= retry_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (out_rdy) begin
                        out_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                DROP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_rdy      = (state_q == IDLE);
    assign out_vld     = out_vld_q;
    assign out_desc    = out_desc_q;
    assign out_port    = out_port_q;
    assign out_port_i  = out_port_i_q;
    assign out_express = out_express_q;
    assign drop_pulse  = drop_pulse_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_tsn_queue_update.sv
// Directed bench for tsn_queue_update: stimulus pushes expected descriptors/drops into a
// scoreboard queue, a negedge monitor pops and compares on each handshake or drop pulse.
module tb_tsn_queue_update;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [7:0]  in_qnum = '0;
    logic [2:0]  in_tc = '0;
    logic [1:0]  in_port_i = '0;
    logic [2:0]  in_port_o = '0;
    logic [15:0] in_addr = '0;
    logic [31:0] port_state = '0;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [23:0] out_desc;
    logic [1:0]  out_port;
    logic [1:0]  out_port_i;
    logic        out_express;
    logic        drop_pulse;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_drop;
        logic [23:0] desc;
        logic [1:0]  port;
        logic [1:0]  port_i;
        logic        express;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_cnt = '0;

    tsn_queue_update dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_qnum(in_qnum), .in_tc(in_tc), .in_port_i(in_port_i),
        .in_port_o(in_port_o), .in_addr(in_addr),
        .port_state(port_state),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_desc(out_desc),
        .out_port(out_port), .out_port_i(out_port_i), .out_express(out_express),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_out(input logic [23:0] d, input logic [1:0] p, input logic [1:0] pi,
                            input logic ex);
        exp_t e;
        e = '{is_drop: 1'b0, desc: d, port: p, port_i: pi, express: ex, cnt: 16'h0};
        exp_q.push_back(e);
    endtask

    task automatic push_drop();
        exp_t e;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e = '{is_drop: 1'b1, desc: 24'h0, port: 2'd0, port_i: 2'd0, express: 1'b0, cnt: exp_cnt};
        exp_q.push_back(e);
    endtask

    // Monitor: one line per observed transaction.
    always @(negedge clk_in) begin
        if (rst_n) begin
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0 || exp_q[0].is_drop) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got desc %0h expected no descriptor", out_desc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("out  desc=%h port=%0d port_i=%0d express=%0d", out_desc, out_port,
                             out_port_i, out_express);
                    chk("out_desc", 32'(out_desc), 32'(e.desc));
                    chk("out_port", 32'(out_port), 32'(e.port));
                    chk("out_port_i", 32'(out_port_i), 32'(e.port_i));
                    chk("out_express", 32'(out_express), 32'(e.express));
                end
            end
            if (drop_pulse) begin
                if (exp_q.size() == 0 || !exp_q[0].is_drop) begin
                    checks++; errors++;
                    $display("FAIL unexpected_drop: got drop_pulse=1 expected 0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("drop drop_cnt=%h", drop_cnt);
                    chk("drop_cnt", 32'(drop_cnt), 32'(e.cnt));
                end
            end
        end
    end

    task automatic send(input logic [7:0] q, input logic [2:0] tc, input logic [1:0] pi,
                        input logic [2:0] po, input logic [15:0] a);
        int waited = 0;
        while (!in_rdy && waited < 40) begin
            @(posedge clk_in); #1;
            waited++;
        end
        chk("in_rdy_before_send", 32'(in_rdy), 32'd1);
        in_vld = 1'b1; in_qnum = q; in_tc = tc; in_port_i = pi; in_port_o = po; in_addr = a;
        @(posedge clk_in); #1;
        // Scramble the request fields after acceptance; the DUT must ignore them.
        in_vld = 1'b0; in_qnum = ~q; in_tc = ~tc; in_port_i = ~pi; in_port_o = 3'd7; in_addr = ~a;
    endtask

    // Counts edges after acceptance until out_vld or drop_pulse appears (bounded).
    task automatic observe(input int open_at, input logic [31:0] open_mask,
                           output int out_lat, output int drop_lat);
        out_lat = -1; drop_lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == open_at) port_state = open_mask;
            @(posedge clk_in); #1;
            if (out_vld) out_lat = n;
            if (drop_pulse) drop_lat = n;
            if (out_lat >= 0 || drop_lat >= 0) break;
        end
    endtask

    initial begin
        int ol, dl;
        repeat (3) @(posedge clk_in);
        #1 rst_n = 1'b1;
        @(posedge clk_in); #1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_desc", 32'(out_desc), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);

        // T1: gate open on p2 tc3
        port_state = 32'h1 << 19;
        push_out(24'h051234, 2'd2, 2'd1, 1'b0);
        send(8'h05, 3'd3, 2'd1, 3'd2, 16'h1234);
        observe(0, 32'h0, ol, dl);
        chk("T1_out_latency", 32'(ol), 32'd2);
        @(posedge clk_in); #1;
        chk("T1_in_rdy_after_hs", 32'(in_rdy), 32'd1);
        chk("T1_out_vld_after_hs", 32'(out_vld), 32'd0);

        // T1b: express boundary, tc == EXPRESS_MIN on the last port
        port_state = 32'h1 << 30;
        push_out(24'h3C00FF, 2'd3, 2'd2, 1'b1);
        send(8'h3C, 3'd6, 2'd2, 3'd3, 16'h00FF);
        observe(0, 32'h0, ol, dl);
        chk("T1b_out_latency", 32'(ol), 32'd2);

        // T2: tc7 on p1, gate closed for three evaluations then opened
        @(posedge clk_in); #1;
        port_state = 32'h0;
        push_out(24'hA7BEEF, 2'd1, 2'd3, 1'b1);
        send(8'hA7, 3'd7, 2'd3, 3'd1, 16'hBEEF);
        observe(5, 32'h1 << 15, ol, dl);
        chk("T2_out_latency", 32'(ol), 32'd5);
        chk("T2_no_drop", 32'(dl), 32'hFFFF_FFFF);

        // T3: only the requested gate (p0 tc2) held closed
        @(posedge clk_in); #1;
        port_state = ~(32'h1 << 2);
        push_drop();
        send(8'h11, 3'd2, 2'd0, 3'd0, 16'h2222);
        observe(0, 32'h0, ol, dl);
        chk("T3_drop_latency", 32'(dl), 32'd16);
        chk("T3_no_out", 32'(ol), 32'hFFFF_FFFF);
        @(posedge clk_in); #1;
        chk("T3_pulse_one_cycle", 32'(drop_pulse), 32'd0);
        chk("T3_drop_cnt", 32'(drop_cnt), 32'd1);

        // T4: invalid egress port
        port_state = 32'hFFFF_FFFF;
        push_drop();
        send(8'h22, 3'd1, 2'd1, 3'd5, 16'h3333);
        observe(0, 32'h0, ol, dl);
        chk("T4_drop_latency", 32'(dl), 32'd2);
        @(posedge clk_in); #1;
        chk("T4_in_rdy", 32'(in_rdy), 32'd1);
        chk("T4_drop_cnt", 32'(drop_cnt), 32'd2);

        // T5: downstream back-pressure for 10 cycles
        out_rdy = 1'b0;
        push_out(24'h99ABCD, 2'd0, 2'd2, 1'b0);
        send(8'h99, 3'd5, 2'd2, 3'd0, 16'hABCD);
        observe(0, 32'h0, ol, dl);
        chk("T5_out_latency", 32'(ol), 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
            chk("T5_hold_vld", 32'(out_vld), 32'd1);
            chk("T5_hold_desc", 32'(out_desc), 32'h99ABCD);
            chk("T5_hold_in_rdy", 32'(in_rdy), 32'd0);
        end
        out_rdy = 1'b1;
        @(posedge clk_in); #1;
        chk("T5_vld_after_hs", 32'(out_vld), 32'd0);
        chk("T5_in_rdy_after_hs", 32'(in_rdy), 32'd1);
        chk("T5_desc_kept", 32'(out_desc), 32'h99ABCD);

        // Saturation: preload counter near the top, then two more drops
        force dut.drop_cnt_q = 16'hFFFE;
        #1 release dut.drop_cnt_q;
        exp_cnt = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            push_drop();
            send(8'h40, 3'd0, 2'd0, 3'd4, 16'h0);
            observe(0, 32'h0, ol, dl);
            chk("SAT_drop_latency", 32'(dl), 32'd2);
        end
        @(posedge clk_in); #1;
        chk("SAT_drop_cnt", 32'(drop_cnt), 32'hFFFF);

        // T6: reset while in JUDGE
        port_state = 32'h0;
        send(8'h77, 3'd4, 2'd1, 3'd1, 16'h5555);
        repeat (4) @(posedge clk_in);
        #1 rst_n = 1'b0;
        #1;
        chk("T6_out_vld", 32'(out_vld), 32'd0);
        chk("T6_out_desc", 32'(out_desc), 32'd0);
        chk("T6_out_port", 32'(out_port), 32'd0);
        chk("T6_out_port_i", 32'(out_port_i), 32'd0);
        chk("T6_out_express", 32'(out_express), 32'd0);
        chk("T6_drop_pulse", 32'(drop_pulse), 32'd0);
        chk("T6_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        port_state = 32'hFFFF_FFFF;
        @(posedge clk_in); #1;
        chk("T6_in_rdy", 32'(in_rdy), 32'd1);
        repeat (20) @(posedge clk_in);
        #1;
        chk("T6_drop_cnt_after", 32'(drop_cnt), 32'd0);
        chk("T6_out_vld_after", 32'(out_vld), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
